// File: rtl/axi4_byte_en_sram_bridge_flat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi4_byte_en_sram_bridge_flat                                            |
// | AXI4 slave serving one read or write burst at a time from a byte-enable  |
// | single-port synchronous SRAM, alternating priority between AW and AR.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi4_byte_en_sram_bridge_flat #(
  parameter int MEM_ADDR_BITS     = 10,
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 1024,
  parameter int AXI_ID_WIDTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXI_ADDRESS_WIDTH-1:0] AWADDR,
  input  logic [AXI_ID_WIDTH-1:0]      AWID,
  input  logic [7:0]                   AWLEN,
  input  logic [2:0]                   AWSIZE,
  input  logic [1:0]                   AWBURST,
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]    WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]  WSTRB,
  input  logic                         WLAST,
  input  logic                         WVALID,
  output logic                         WREADY,
  output logic [AXI_ID_WIDTH-1:0]      BID,
  output logic [1:0]                   BRESP,
  output logic                         BVALID,
  input  logic                         BREADY,
  input  logic [AXI_ADDRESS_WIDTH-1:0] ARADDR,
  input  logic [AXI_ID_WIDTH-1:0]      ARID,
  input  logic [7:0]                   ARLEN,
  input  logic [2:0]                   ARSIZE,
  input  logic [1:0]                   ARBURST,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [AXI_ID_WIDTH-1:0]      RID,
  output logic [AXI_DATA_WIDTH-1:0]    RDATA,
  output logic [1:0]                   RRESP,
  output logic                         RLAST,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [MEM_ADDR_BITS-1:0]     sram_addr,
  output logic                         sram_read_en,
  output logic                         sram_write_en,
  output logic [AXI_DATA_WIDTH-1:0]    sram_write_data,
  output logic [AXI_DATA_WIDTH/8-1:0]  sram_byte_en,
  input  logic [AXI_DATA_WIDTH-1:0]    sram_read_data
);

  localparam int c_STRB_W = AXI_DATA_WIDTH / 8;
  localparam int c_LSB    = $clog2(c_STRB_W);

  localparam logic [2:0] c_S_IDLE    = 3'd0;
  localparam logic [2:0] c_S_WDATA   = 3'd1;
  localparam logic [2:0] c_S_WRESP   = 3'd2;
  localparam logic [2:0] c_S_RD_REQ  = 3'd3;
  localparam logic [2:0] c_S_RD_CAPT = 3'd4;
  localparam logic [2:0] c_S_RD_RESP = 3'd5;

  logic [2:0]                r_state;
  logic [2:0]                w_state_nxt;
  logic [MEM_ADDR_BITS-1:0]  r_addr;
  logic [MEM_ADDR_BITS-1:0]  w_addr_nxt;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [7:0]                r_len;
  logic [7:0]                r_cnt;
  logic                      r_fixed;
  logic                      r_prio_rd;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic                      w_sel_wr;
  logic                      w_sel_rd;
  logic                      w_last;
  logic                      w_unused;

  // Size, WLAST and the address bits outside the word index carry no meaning here.
  assign w_unused = ^{AWSIZE, ARSIZE, WLAST, AWADDR, ARADDR};

  assign w_sel_wr   = AWVALID && (!ARVALID || !r_prio_rd);
  assign w_sel_rd   = ARVALID && (!AWVALID || r_prio_rd);
  assign w_last     = (r_cnt == r_len);
  assign w_addr_nxt = r_fixed ? r_addr : r_addr + {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_sel_wr) begin
          w_state_nxt = c_S_WDATA;
        end else if (w_sel_rd) begin
          w_state_nxt = c_S_RD_REQ;
        end
      end
      c_S_WDATA:   if (WVALID && w_last) w_state_nxt = c_S_WRESP;
      c_S_WRESP:   if (BREADY) w_state_nxt = c_S_IDLE;
      c_S_RD_REQ:  w_state_nxt = c_S_RD_CAPT;
      c_S_RD_CAPT: w_state_nxt = c_S_RD_RESP;
      c_S_RD_RESP: if (RREADY) w_state_nxt = w_last ? c_S_IDLE : c_S_RD_REQ;
      default:     w_state_nxt = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_id      <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_fixed   <= 1'b0;
      r_prio_rd <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_sel_wr) begin
            r_id      <= AWID;
            r_addr    <= AWADDR[c_LSB +: MEM_ADDR_BITS];
            r_len     <= AWLEN;
            r_fixed   <= (AWBURST == 2'b00);
            r_cnt     <= '0;
            r_prio_rd <= ~r_prio_rd;
          end else if (w_sel_rd) begin
            r_id      <= ARID;
            r_addr    <= ARADDR[c_LSB +: MEM_ADDR_BITS];
            r_len     <= ARLEN;
            r_fixed   <= (ARBURST == 2'b00);
            r_cnt     <= '0;
            r_prio_rd <= ~r_prio_rd;
          end
        end
        c_S_WDATA: begin
          if (WVALID) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= w_addr_nxt;
          end
        end
        c_S_RD_CAPT: r_rdata <= sram_read_data;
        c_S_RD_RESP: begin
          if (RREADY && !w_last) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= w_addr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign BID       = r_id;
  assign RID       = r_id;
  assign RDATA     = r_rdata;
  assign BRESP     = 2'b00;
  assign RRESP     = 2'b00;
  assign sram_addr = r_addr;

  always_comb begin
    AWREADY         = 1'b0;
    ARREADY         = 1'b0;
    WREADY          = 1'b0;
    BVALID          = 1'b0;
    RVALID          = 1'b0;
    RLAST           = 1'b0;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    sram_write_data = '0;
    sram_byte_en    = '0;
    case (r_state)
      c_S_IDLE: begin
        AWREADY = w_sel_wr && !rst;
        ARREADY = w_sel_rd && !rst;
      end
      c_S_WDATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          sram_write_en   = 1'b1;
          sram_write_data = WDATA;
          sram_byte_en    = WSTRB;
        end
      end
      c_S_WRESP:  BVALID = 1'b1;
      c_S_RD_REQ: sram_read_en = 1'b1;
      c_S_RD_RESP: begin
        RVALID = 1'b1;
        RLAST  = w_last;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_byte_en_sram_bridge_flat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi4_byte_en_sram_bridge_flat                                         |
// | Scoreboard bench: directed plus random bursts against an SRAM model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axi4_byte_en_sram_bridge_flat;
  localparam int MAB = 10;
  localparam int DW  = 32;
  localparam int IDW = 4;
  localparam int SW  = DW / 8;
  localparam int TO  = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] AWADDR, ARADDR;
  logic [IDW-1:0] AWID, ARID, BID, RID;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
  logic AWVALID, AWREADY, ARVALID, ARREADY, WLAST, WVALID, WREADY;
  logic BVALID, BREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA, sram_write_data, sram_read_data;
  logic [SW-1:0] WSTRB, sram_byte_en;
  logic [MAB-1:0] sram_addr;
  logic sram_read_en, sram_write_en;

  axi4_byte_en_sram_bridge_flat #(
    .MEM_ADDR_BITS(MAB), .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_write_data(sram_write_data), .sram_byte_en(sram_byte_en),
    .sram_read_data(sram_read_data)
  );

  // SRAM macro: byte-enabled write, registered read data one cycle after read_en.
  logic [DW-1:0] mem [0:(1<<MAB)-1];
  always @(posedge clk) begin
    if (sram_write_en) begin
      for (int b = 0; b < SW; b++)
        if (sram_byte_en[b]) mem[sram_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
    end
    if (sram_read_en) sram_read_data <= mem[sram_addr];
  end

  // Reference model and scoreboards.
  logic [DW-1:0] ref_mem [0:(1<<MAB)-1];
  typedef struct packed { logic [MAB-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; } sw_t;
  typedef struct packed { logic [IDW-1:0] id; logic [DW-1:0] d; logic last; } r_t;
  sw_t sw_q[$];
  logic [IDW-1:0] b_q[$];
  r_t r_q[$];
  logic [DW-1:0] wdat [0:255];
  logic [SW-1:0] wstb [0:255];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected expected handshake at %0t", name, $time);
  endtask

  logic hold_v;
  logic [DW-1:0] hold_d;
  logic hold_l;
  logic [IDW-1:0] hold_id;

  always @(negedge clk) begin : mon
    sw_t es;
    r_t er;
    logic [IDW-1:0] eb;
    if (rst) begin
      hold_v <= 1'b0;
    end else begin
      if (sram_write_en || sram_read_en)
        chk("sram_both_en", 64'(sram_write_en & sram_read_en), 64'd0);
      if (sram_write_en) begin
        if (sw_q.size() == 0) fail_now("sram_wr_unexpected");
        else begin
          es = sw_q.pop_front();
          chk("sram_addr", 64'(sram_addr), 64'(es.a));
          chk("sram_wdata", 64'(sram_write_data), 64'(es.d));
          chk("sram_be", 64'(sram_byte_en), 64'(es.s));
        end
      end
      if (BVALID && BREADY) begin
        if (b_q.size() == 0) fail_now("b_unexpected");
        else begin
          eb = b_q.pop_front();
          chk("bid", 64'(BID), 64'(eb));
          chk("bresp", 64'(BRESP), 64'd0);
        end
      end
      if (hold_v) begin
        chk("r_hold_valid", 64'(RVALID), 64'd1);
        chk("r_hold_data", 64'(RDATA), 64'(hold_d));
        chk("r_hold_last", 64'(RLAST), 64'(hold_l));
        chk("r_hold_id", 64'(RID), 64'(hold_id));
      end
      if (RVALID && RREADY) begin
        if (r_q.size() == 0) fail_now("r_unexpected");
        else begin
          er = r_q.pop_front();
          chk("rid", 64'(RID), 64'(er.id));
          chk("rdata", 64'(RDATA), 64'(er.d));
          chk("rlast", 64'(RLAST), 64'(er.last));
          chk("rresp", 64'(RRESP), 64'd0);
        end
      end
      hold_v  <= RVALID && !RREADY;
      hold_d  <= RDATA;
      hold_l  <= RLAST;
      hold_id <= RID;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_write(input logic [31:0] addr, input logic [IDW-1:0] id,
                          input logic [7:0] len, input logic [1:0] burst);
    int a = int'(addr[MAB+1:2]);
    int to;
    for (int i = 0; i <= int'(len); i++) begin
      sw_q.push_back('{a: MAB'(a), d: wdat[i], s: wstb[i]});
      for (int b = 0; b < SW; b++)
        if (wstb[i][b]) ref_mem[a][8*b +: 8] = wdat[i][8*b +: 8];
      if (burst != 2'd0) a = (a + 1) % (1 << MAB);
    end
    b_q.push_back(id);
    AWADDR = addr; AWID = id; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
    to = 0;
    @(negedge clk);
    while (!AWREADY && to < TO) begin @(negedge clk); to++; end
    if (to >= TO) fail_now("aw_timeout");
    @(posedge clk); #1 AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      repeat ($urandom % 3) begin @(posedge clk); #1; end
      WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == int'(len)); WVALID = 1'b1;
      to = 0;
      @(negedge clk);
      while (!WREADY && to < TO) begin @(negedge clk); to++; end
      if (to >= TO) fail_now("w_timeout");
      @(posedge clk); #1 WVALID = 1'b0; WLAST = 1'b0;
    end
    repeat ($urandom % 3) begin @(posedge clk); #1; end
    BREADY = 1'b1;
    to = 0;
    @(negedge clk);
    while (!BVALID && to < TO) begin @(negedge clk); to++; end
    if (to >= TO) fail_now("b_timeout");
    @(posedge clk); #1 BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [IDW-1:0] id,
                         input logic [7:0] len, input logic [1:0] burst, input bit hold5);
    int a = int'(addr[MAB+1:2]);
    int to;
    bit done;
    for (int i = 0; i <= int'(len); i++) begin
      r_q.push_back('{id: id, d: ref_mem[a], last: (i == int'(len))});
      if (burst != 2'd0) a = (a + 1) % (1 << MAB);
    end
    ARADDR = addr; ARID = id; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
    RREADY = 1'b0;
    to = 0;
    @(negedge clk);
    while (!ARREADY && to < TO) begin @(negedge clk); to++; end
    if (to >= TO) fail_now("ar_timeout");
    @(posedge clk); #1 ARVALID = 1'b0;
    @(negedge clk);
    chk("rd_lat_read_en", 64'(sram_read_en), 64'd1);
    chk("rd_lat_rvalid_t1", 64'(RVALID), 64'd0);
    @(negedge clk);
    chk("rd_lat_rvalid_t2", 64'(RVALID), 64'd0);
    @(negedge clk);
    chk("rd_lat_rvalid_t3", 64'(RVALID), 64'd1);
    if (hold5) repeat (5) begin @(posedge clk); #1 RREADY = 1'b0; end
    done = 1'b0;
    to = 0;
    while (!done && to < 4 * TO) begin
      @(posedge clk); #1 RREADY = ($urandom % 4 != 0);
      @(negedge clk);
      if (RVALID && RREADY && RLAST) done = 1'b1;
      to++;
    end
    if (!done) fail_now("r_timeout");
    @(posedge clk); #1 RREADY = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << MAB); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    AWADDR = '0; AWID = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    ARADDR = '0; ARID = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    apply_reset();

    @(negedge clk);
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_wready", 64'(WREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_sram_en", 64'({sram_read_en, sram_write_en}), 64'd0);
    chk("rst_ids", 64'({BID, RID}), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_resp", 64'({BRESP, RRESP}), 64'd0);
    @(posedge clk); #1;

    // Single write and readback.
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    do_write(32'h80, 4'd3, 8'd0, 2'd1);
    do_read(32'h80, 4'd5, 8'd0, 2'd1, 1'b0);

    // INCR burst of four.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    do_write(32'h14, 4'd1, 8'd3, 2'd1);
    do_read(32'h14, 4'd2, 8'd3, 2'd1, 1'b0);

    // Byte strobes.
    wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF;
    do_write(32'h40, 4'd4, 8'd0, 2'd1);
    wdat[0] = 32'h11223344; wstb[0] = 4'h5;
    do_write(32'h40, 4'd4, 8'd0, 2'd1);
    do_read(32'h40, 4'd6, 8'd0, 2'd1, 1'b0);
    chk("strobe_ref", 64'(ref_mem[16]), 64'h00000000FF22FF44);

    // FIXED bursts.
    for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    do_write(32'h60, 4'd7, 8'd2, 2'd0);
    do_read(32'h60, 4'd8, 8'd2, 2'd0, 1'b0);

    // Simultaneous AW/AR after reset: write wins, read stalls and is backpressured.
    apply_reset();
    wdat[0] = 32'hCAFEF00D; wstb[0] = 4'hF;
    fork
      do_write(32'h200, 4'd9, 8'd0, 2'd1);
      do_read(32'h80, 4'd10, 8'd0, 2'd1, 1'b1);
      begin
        @(negedge clk);
        chk("arb_awready", 64'(AWREADY), 64'd1);
        chk("arb_arready", 64'(ARREADY), 64'd0);
      end
    join

    // Address wrap from the top word.
    wdat[0] = 32'hA5A5A5A5; wstb[0] = 4'hF;
    wdat[1] = 32'h5A5A5A5A; wstb[1] = 4'hF;
    do_write(32'hFFC, 4'd11, 8'd1, 2'd2);
    do_read(32'hFFC, 4'd12, 8'd1, 2'd1, 1'b0);

    // Reset in the middle of a write burst: one beat lands, no B response.
    sw_q.push_back('{a: MAB'(100), d: 32'h12345678, s: 4'hF});
    ref_mem[100] = 32'h12345678;
    AWADDR = 32'd400; AWID = 4'd13; AWLEN = 8'd3; AWBURST = 2'd1; AWVALID = 1'b1;
    @(negedge clk);
    chk("mid_awready", 64'(AWREADY), 64'd1);
    @(posedge clk); #1 AWVALID = 1'b0;
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge clk); #1 WVALID = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    WVALID = 1'b1; WDATA = 32'hBAD0BAD0;
    repeat (3) begin
      @(negedge clk);
      chk("mid_bvalid", 64'(BVALID), 64'd0);
      chk("mid_wready", 64'(WREADY), 64'd0);
    end
    @(posedge clk); #1 WVALID = 1'b0;
    do_read(32'd400, 4'd14, 8'd1, 2'd1, 1'b0);

    // Random traffic.
    for (int t = 0; t < 30; t++) begin
      if ($urandom % 2 == 0) begin
        for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = SW'($urandom); end
        do_write($urandom, IDW'($urandom), 8'($urandom % 8), 2'($urandom % 3));
      end else begin
        do_read($urandom, IDW'($urandom), 8'($urandom % 8), 2'($urandom % 3),
                ($urandom % 4 == 0));
      end
    end

    repeat (5) @(posedge clk);
    chk("drain_sw_q", 64'(sw_q.size()), 64'd0);
    chk("drain_b_q", 64'(b_q.size()), 64'd0);
    chk("drain_r_q", 64'(r_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
